// File: rtl/adder.sv
// Parameterised adder: combinational {Cout,S} = A + B + Cin plus a registered copy with signed overflow.
// Define ADDER_CLA_EN to build the carry chain from 4-bit lookahead groups instead of a plain ripple chain.
module adder #(
    parameter int unsigned OPERAND_BIT = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [OPERAND_BIT-1:0] A,
    input  logic [OPERAND_BIT-1:0] B,
    input  logic                   Cin,
    output logic [OPERAND_BIT-1:0] S,
    output logic                   Cout,
    output logic [OPERAND_BIT-1:0] S_q,
    output logic                   Cout_q,
    output logic                   V_q
);

    localparam int unsigned MSB = OPERAND_BIT - 1;

    logic [OPERAND_BIT-1:0] sum;
    logic                   carry_out;
    logic                   ovf;

`ifdef ADDER_CLA_EN
    localparam int unsigned NGRP = (OPERAND_BIT + 3) / 4;
    localparam int unsigned WP   = NGRP * 4;

    logic [WP-1:0] pe;
    logic [WP-1:0] ge;
    logic [WP-1:0] sum_w;
    logic [WP+3:0] sum_ext;
    logic [3:0]    p4;
    logic [3:0]    g4;
    logic [3:0]    c4v;
    logic          carry;

    // Padding bits propagate (p=1, g=0), so the last partial group's carry-out is the carry at bit OPERAND_BIT.
    always_comb begin
        pe      = '1;
        ge      = '0;
        pe[OPERAND_BIT-1:0] = A ^ B;
        ge[OPERAND_BIT-1:0] = A & B;
        sum_w   = '0;
        sum_ext = '0;
        p4      = '0;
        g4      = '0;
        c4v     = '0;
        carry   = Cin;
        for (int unsigned gi = 0; gi < NGRP; gi++) begin
            p4     = pe[3:0];
            g4     = ge[3:0];
            c4v[0] = carry;
            c4v[1] = g4[0] | (p4[0] & carry);
            c4v[2] = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & carry);
            c4v[3] = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0])
                   | (p4[2] & p4[1] & p4[0] & carry);
            carry  = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1])
                   | (p4[3] & p4[2] & p4[1] & g4[0]) | (&p4 & carry);
            sum_ext = {p4 ^ c4v, sum_w};
            sum_w   = sum_ext[WP+3:4];
            pe      = pe >> 4;
            ge      = ge >> 4;
        end
        sum       = sum_w[OPERAND_BIT-1:0];
        carry_out = carry;
    end
`else
    logic [OPERAND_BIT-1:0] pv;
    logic [OPERAND_BIT-1:0] gv;
    logic [OPERAND_BIT-1:0] sum_r;
    logic [OPERAND_BIT:0]   sum_ext;
    logic                   carry;

    // Bits are consumed from the LSB and sum bits shifted in at the MSB, keeping every select constant.
    always_comb begin
        pv      = A ^ B;
        gv      = A & B;
        sum_r   = '0;
        sum_ext = '0;
        carry   = Cin;
        for (int unsigned i = 0; i < OPERAND_BIT; i++) begin
            sum_ext = {pv[0] ^ carry, sum_r};
            sum_r   = sum_ext[OPERAND_BIT:1];
            carry   = gv[0] | (pv[0] & carry);
            pv      = pv >> 1;
            gv      = gv >> 1;
        end
        sum       = sum_r;
        carry_out = carry;
    end
`endif

    always_comb begin
        ovf = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
    end

    assign S    = sum;
    assign Cout = carry_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S_q    <= '0;
            Cout_q <= 1'b0;
            V_q    <= 1'b0;
        end else begin
            S_q    <= sum;
            Cout_q <= carry_out;
            V_q    <= ovf;
        end
    end

endmodule

// File: tb/tb_adder.sv
// Bench for adder at widths 1, 10 and 33: directed cases, async reset behaviour, randomized sweep.
module tb_adder;

    logic clk = 1'b0;
    logic rst_n;
    logic cin;

    logic [0:0]  a1, b1, s1, sq1;
    logic        co1, coq1, vq1;
    logic [9:0]  a10, b10, s10, sq10;
    logic        co10, coq10, vq10;
    logic [32:0] a33, b33, s33, sq33;
    logic        co33, coq33, vq33;

    logic [65:0] e1, e10, e33;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    adder #(.OPERAND_BIT(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .Cin(cin),
        .S(s1), .Cout(co1), .S_q(sq1), .Cout_q(coq1), .V_q(vq1)
    );
    adder #(.OPERAND_BIT(10)) u_w10 (
        .clk(clk), .rst_n(rst_n), .A(a10), .B(b10), .Cin(cin),
        .S(s10), .Cout(co10), .S_q(sq10), .Cout_q(coq10), .V_q(vq10)
    );
    adder #(.OPERAND_BIT(33)) u_w33 (
        .clk(clk), .rst_n(rst_n), .A(a33), .B(b33), .Cin(cin),
        .S(s33), .Cout(co33), .S_q(sq33), .Cout_q(coq33), .V_q(vq33)
    );

    task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: integer sum for {Cout,S}; overflow as "signed result out of range".
    function automatic logic [65:0] model(input int unsigned w, input logic [63:0] a,
                                          input logic [63:0] b, input logic ci);
        logic [63:0] mask;
        logic [64:0] full;
        logic [63:0] s;
        logic        co;
        longint      sa, sb, tot, lim;
        mask = (64'd1 << w) - 64'd1;
        full = {1'b0, a & mask} + {1'b0, b & mask} + {64'd0, ci};
        s    = full[63:0] & mask;
        co   = |((full >> w) & 65'd1);
        lim  = longint'(64'd1 << (w - 1));
        sa   = longint'(a & mask);
        sb   = longint'(b & mask);
        if (sa >= lim) sa = sa - 2 * lim;
        if (sb >= lim) sb = sb - 2 * lim;
        tot  = sa + sb + (ci ? 64'sd1 : 64'sd0);
        return {(tot >= lim) || (tot < -lim), co, s};
    endfunction

    task automatic apply(input logic [63:0] a, input logic [63:0] b, input logic ci);
        a1  = a[0:0];   b1  = b[0:0];
        a10 = a[9:0];   b10 = b[9:0];
        a33 = a[32:0];  b33 = b[32:0];
        cin = ci;
        e1  = model(1,  a, b, ci);
        e10 = model(10, a, b, ci);
        e33 = model(33, a, b, ci);
    endtask

    task automatic check_comb(input string tag);
        check({tag, " w1 comb"},  {1'b0, co1,  64'(s1)},  {1'b0, e1[64:0]});
        check({tag, " w10 comb"}, {1'b0, co10, 64'(s10)}, {1'b0, e10[64:0]});
        check({tag, " w33 comb"}, {1'b0, co33, 64'(s33)}, {1'b0, e33[64:0]});
    endtask

    task automatic check_reg(input string tag, input logic zero);
        check({tag, " w1 reg"},  {vq1,  coq1,  64'(sq1)},  zero ? '0 : e1);
        check({tag, " w10 reg"}, {vq10, coq10, 64'(sq10)}, zero ? '0 : e10);
        check({tag, " w33 reg"}, {vq33, coq33, 64'(sq33)}, zero ? '0 : e33);
    endtask

    task automatic step(input string tag, input logic [63:0] a, input logic [63:0] b, input logic ci);
        @(negedge clk);
        apply(a, b, ci);
        #1 check_comb(tag);
        @(posedge clk);
        #1 check_reg(tag, 1'b0);
    endtask

    logic [63:0] ra, rb;

    initial begin
        rst_n = 1'b0;
        apply(64'h348, 64'h1D7, 1'b0);
        #1 check_reg("reset", 1'b1);
        check_comb("comb during reset");
        repeat (2) @(posedge clk);
        #1 check_reg("reset held", 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        step("mixed signs",   64'h348, 64'h1D7, 1'b0);
        check("vec1 w10 exact", {vq10, coq10, 64'(sq10)}, {1'b0, 1'b1, 64'h11F});
        step("cin wrap",      64'h3FF, 64'h000, 1'b1);
        check("vec2 w10 exact", {vq10, coq10, 64'(sq10)}, {1'b0, 1'b1, 64'h000});
        step("pos overflow",  64'h1FF, 64'h001, 1'b0);
        check("vec3 w10 exact", {vq10, coq10, 64'(sq10)}, {1'b1, 1'b0, 64'h200});
        step("neg overflow",  64'h200, 64'h200, 1'b0);
        check("vec4 w10 exact", {vq10, coq10, 64'(sq10)}, {1'b1, 1'b1, 64'h000});
        step("33b full carry", 64'h1_FFFF_FFFF, 64'h1_FFFF_FFFF, 1'b1);

        // Asynchronous reset between edges with registers holding nonzero values
        step("preload", 64'h348, 64'h1D7, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_reg("async clear", 1'b1);
        check_comb("comb unaffected by reset");
        @(negedge clk);
        apply(64'h1FF, 64'h001, 1'b0);
        #1 check_comb("comb tracks in reset");
        @(posedge clk);
        #1 check_reg("held in reset", 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_reg("no capture before edge", 1'b1);
        @(posedge clk);
        #1 check_reg("reload after release", 1'b0);

        for (int i = 0; i < 10000; i++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            case ($urandom_range(0, 7))
                0: ra = '1;
                1: rb = '0;
                2: begin ra = 64'h1_0000_0200; rb = 64'h1_0000_0200; end
                default: ;
            endcase
            step("random", ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adder.md
# adder

Parameterised two's-complement/unsigned adder computing S = A + B + Cin over OPERAND_BIT bits with carry-out. It is the base arithmetic primitive of the ArithmeticOperator group, feeding accumulators and MAC datapaths. It has two result views:
- a combinational result (S, Cout);
- a one-cycle registered copy with signed-overflow flag (S_q, Cout_q, V_q) for pipelined consumers.

## Interface
- OPERAND_BIT, default 10: operand/sum width in bits; legal range 1 to 64.
- clk  input  1  rising-edge clock for registered outputs.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- A  input  OPERAND_BIT  operand A; unsigned or two's complement, same bits.
- B  input  OPERAND_BIT  operand B.
- Cin  input  1  carry-in, weight 1.
- S  output  OPERAND_BIT  combinational sum, low OPERAND_BIT bits of A+B+Cin.
- Cout  output  1  combinational carry-out (bit OPERAND_BIT of A+B+Cin).
- S_q  output  OPERAND_BIT  S registered.
- Cout_q  output  1  Cout registered.
- V_q  output  1  registered signed overflow: (A[msb]==B[msb]) && (S[msb]!=A[msb]).

## Operation
- {Cout,S} = A + B + Cin, evaluated as an (OPERAND_BIT+1)-bit unsigned sum with no truncation of the carry.
- Sign interpretation is the consumer's choice. Cout is the unsigned carry; the signed overflow is derived from operand/result MSBs, independent of Cin's sign.
- S wraps modulo 2^OPERAND_BIT. No saturation.
- S and Cout are purely combinational. They depend only on A, B and Cin, not on clk or rst_n, and are valid during reset.
- Carry chain is built from full-adder cells. Generate/propagate per bit: g=A&B, p=A^B, S=p^c, c_next=g|(p&c).
- No X propagation beyond inputs. With all inputs known, all outputs are known.

## Timing
- S/Cout: zero-cycle latency. They settle within one combinational path after any input change.
- S_q/Cout_q/V_q: one-cycle latency. They capture the S/Cout/V values present at each rising clk edge and load every cycle, with no enable.
- Reset: rst_n low forces S_q=0, Cout_q=0, V_q=0 immediately, without waiting for clk. The registers hold 0 while rst_n is low.
- First capture is on the first rising edge after rst_n deasserts.
- Reset asserted mid-operation: registered outputs clear at once; combinational outputs unaffected.
- Inputs changing at the edge: the value meeting setup at the edge is captured. There is no internal hold state.

## Configuration
- ADDER_CLA_EN defined: carry chain is built from 4-bit carry-lookahead groups with ripple between groups. A final partial group handles OPERAND_BIT not a multiple of 4.
- ADDER_CLA_EN undefined: plain ripple-carry chain of OPERAND_BIT full adders.
- All outputs are bit-identical in both builds; only structure and critical path differ.

## Test plan
- OPERAND_BIT=10, A=-184 (0x348), B=471 (0x1D7), Cin=0 -> within 10 ns, S=287 (0x11F), Cout=1; after next clk edge S_q=0x11F, Cout_q=1, V_q=0.
- A=0x3FF, B=0x000, Cin=1 -> S=0x000, Cout=1; after edge V_q=0.
- A=0x1FF (511), B=0x001, Cin=0 -> S=0x200, Cout=0; after edge V_q=1 (positive overflow).
- A=0x200, B=0x200, Cin=0 -> S=0x000, Cout=1; after edge V_q=1 (negative overflow).
- Registers loaded nonzero, then rst_n=0 between edges -> S_q, Cout_q, V_q read 0 immediately while S/Cout still track inputs. Release rst_n -> reload on next edge.
- Random sweep of 10k vectors at OPERAND_BIT=1, 10 and 33, in both ADDER_CLA_EN builds -> {Cout,S} equals the reference sum A+B+Cin each time.
